// File: rtl/rle_top.sv
// Run-length encoder for one 8x10 block of quantized coefficients.
// Each clock consumes one row; the encoded (run, value) pairs are published when row 7 lands.
module rle_top (
  input  logic         clk,
  input  logic         reset,
  input  logic [79:0]  in,
  output logic [319:0] out
);

  localparam int unsigned NCOEF  = 10;
  localparam int unsigned NPAIR  = 20;
  localparam logic [2:0]  LAST_ROW = 3'd7;

  logic [2:0]   row_q, row_d;
  logic [7:0]   run_q, run_d;
  logic [4:0]   idx_q, idx_d;
  logic [319:0] buf_q, buf_d;
  logic [319:0] out_q, out_d;

  logic [7:0]   scan_run_s;
  logic [4:0]   scan_idx_s;
  logic [319:0] scan_buf_s;
  logic [7:0]   coef_s;

  // Ten chained scan steps over the current row, starting from the registered block state
  always_comb begin
    scan_run_s = run_q;
    scan_idx_s = idx_q;
    scan_buf_s = buf_q;
    coef_s     = 8'd0;
    for (int i = 0; i < NCOEF; i++) begin
      coef_s = in[79-8*i -: 8];
      if (coef_s == 8'd0) begin
        scan_run_s = scan_run_s + 8'd1;
      end else begin
        // Slots past the 20th are never written, so overflow nonzeros simply drop out
        for (int k = 0; k < NPAIR; k++) begin
          if (scan_idx_s == 5'(k)) begin
            scan_buf_s[319-16*k -: 16] = {scan_run_s, coef_s};
          end else begin
            scan_buf_s = scan_buf_s;
          end
        end
        if (scan_idx_s < 5'd20) begin
          scan_idx_s = scan_idx_s + 5'd1;
        end else begin
          scan_idx_s = scan_idx_s;
        end
        scan_run_s = 8'd0;
      end
    end
  end

  // Next-state selection: publish and clear on the last row, otherwise carry the scan forward
  always_comb begin
    row_d = row_q;
    run_d = run_q;
    idx_d = idx_q;
    buf_d = buf_q;
    out_d = out_q;
    if (row_q == LAST_ROW) begin
      row_d = 3'd0;
      run_d = 8'd0;
      idx_d = 5'd0;
      buf_d = 320'd0;
      out_d = scan_buf_s;
    end else begin
      row_d = row_q + 3'd1;
      run_d = scan_run_s;
      idx_d = scan_idx_s;
      buf_d = scan_buf_s;
      out_d = out_q;
    end
  end

  // State registers; reset discards any partially collected block
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= 3'd0;
      run_q <= 8'd0;
      idx_q <= 5'd0;
      buf_q <= 320'd0;
      out_q <= 320'd0;
    end else begin
      row_q <= row_d;
      run_q <= run_d;
      idx_q <= idx_d;
      buf_q <= buf_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_rle_top.sv
// Bench for rle_top: a whole-block reference encoder checked every cycle,
// plus literal expectations for the documented example, max-run and overflow blocks.
module tb_rle_top;

  logic         clk;
  logic         reset;
  logic [79:0]  in;
  logic [319:0] out;

  int checks;
  int failures;

  rle_top dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: gather 80 coefficients, encode the whole block when it is complete
  logic [7:0]   blk [80];
  int           nrows;
  logic [319:0] exp_out;
  bit           model_valid;

  function automatic logic [319:0] encode_block();
    logic [319:0] r;
    int run;
    int n;
    r   = '0;
    run = 0;
    n   = 0;
    for (int i = 0; i < 80; i++) begin
      if (blk[i] == 8'h00) begin
        run++;
      end else begin
        if (n < 20) r[319-16*n -: 16] = {8'(run), blk[i]};
        n++;
        run = 0;
      end
    end
    return r;
  endfunction

  initial begin
    nrows       = 0;
    exp_out     = '0;
    model_valid = 1'b0;
  end

  always @(posedge clk) begin
    if (reset) begin
      exp_out     = '0;
      nrows       = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      for (int j = 0; j < 10; j++) blk[nrows*10+j] = in[79-8*j -: 8];
      nrows++;
      if (nrows == 8) begin
        exp_out = encode_block();
        nrows   = 0;
      end
    end
  end

  // Cycle-by-cycle comparison, sampled on the falling edge
  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (out !== exp_out) begin
        failures++;
        $display("FAIL cycle_out t=%0t actual=%h required=%h", $time, out, exp_out);
      end
    end
  end

  task automatic check_lit(input string name, input logic [319:0] act, input logic [319:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic apply(input logic [79:0] row, input logic r);
    in    = row;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  // Block ids: 0 = example, 1 = max run, 2 = all ones, 3 = all zero
  function automatic logic [79:0] blk_row(input int id, input int r);
    logic [79:0] ex [8];
    ex[0] = 80'h42_01_00_00_00_00_00_00_00_00;
    ex[1] = 80'h00_00_00_00_00_00_0C_00_00_00;
    ex[2] = 80'h00_00_00_00_00_00_00_00_00_00;
    ex[3] = 80'h0B_FF_00_00_00_00_00_00_00_00;
    ex[4] = 80'h01_FF_00_DD_00_00_00_00_00_00;
    ex[5] = 80'h00_00_01_DD_00_00_00_00_00_00;
    ex[6] = 80'h00_00_07_00_00_00_00_00_00_00;
    ex[7] = 80'h00_00_00_00_00_00_00_00_00_00;
    case (id)
      0:       return ex[r];
      1:       return (r == 7) ? 80'h00_00_00_00_00_00_00_00_00_05 : 80'h0;
      2:       return {10{8'h01}};
      default: return 80'h0;
    endcase
  endfunction

  task automatic run_block(input int id);
    for (int r = 0; r < 8; r++) apply(blk_row(id, r), 1'b0);
  endtask

  logic [319:0] ex_res;
  logic [319:0] mr_res;
  logic [319:0] ov_res;

  initial begin
    checks   = 0;
    failures = 0;
    ex_res   = {176'h0042_0001_0E0C_0D0B_00FF_0801_00FF_01DD_0801_00DD_0807, 144'h0};
    mr_res   = {16'h4F05, 304'h0};
    ov_res   = {20{16'h0001}};
    in       = 80'h0;
    reset    = 1'b1;

    apply({$urandom, $urandom, 16'($urandom)}, 1'b1);
    apply({$urandom, $urandom, 16'($urandom)}, 1'b1);
    check_lit("reset_out", out, 320'h0);

    run_block(3);
    check_lit("zero_block", out, 320'h0);

    run_block(0);
    check_lit("example_dut", out, ex_res);
    check_lit("example_model", exp_out, ex_res);

    for (int r = 0; r < 7; r++) begin
      apply(blk_row(1, r), 1'b0);
      check_lit("example_hold", out, ex_res);
    end
    apply(blk_row(1, 7), 1'b0);
    check_lit("maxrun_dut", out, mr_res);
    check_lit("maxrun_model", exp_out, mr_res);

    run_block(2);
    check_lit("overflow_dut", out, ov_res);
    check_lit("overflow_model", exp_out, ov_res);

    run_block(0);
    check_lit("after_overflow", out, ex_res);

    for (int r = 0; r < 4; r++) apply(blk_row(0, r), 1'b0);
    apply(80'hFF_FF_FF_FF_FF_FF_FF_FF_FF_FF, 1'b1);
    check_lit("midblock_reset", out, 320'h0);
    for (int r = 0; r < 7; r++) begin
      apply(blk_row(0, r), 1'b0);
      check_lit("post_reset_hold", out, 320'h0);
    end
    apply(blk_row(0, 7), 1'b0);
    check_lit("post_reset_example", out, ex_res);

    for (int r = 0; r < 7; r++) apply(blk_row(2, r), 1'b0);
    apply(blk_row(2, 7), 1'b1);
    check_lit("reset_on_row7", out, 320'h0);

    run_block(1);
    check_lit("final_maxrun", out, mr_res);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
